stopwatch_ctrl: RTL and testbench

- Control and sequencing block for the two-digit seconds stopwatch datapath.
- Conditions four raw push-buttons: synchronise, debounce, edge-detect.
- Runs a run/pause/lap state machine and generates the 1-second count-enable, counter-clear and display-freeze controls.
- The digit counters and 7-segment lookup stay in the datapath; this block owns when they count, clear and refresh.

---
 rtl/stopwatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions four push-buttons and runs the run/pause/lap FSM
// that decides when the seconds datapath counts, clears and freezes its display.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       tick_en,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic       running,
    output logic [1:0] state,
    output logic [3:0] lap_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_q;
    logic [3:0]    press;
    logic [DW-1:0] deb_cnt [4];

    state_t        cur;
    logic [PW-1:0] presc;
    logic          p_start;
    logic          p_stop;
    logic          p_lap;
    logic          p_clear;
    logic [3:0]    lap_next;

    assign raw = {btn_clear, btn_lap, btn_stop, btn_start};

    // Each button: two-flop synchroniser, then a level is accepted only after
    // DEB_CYCLES consecutive cycles of disagreement with the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press   = deb & ~deb_q;
    assign p_start = press[0];
    assign p_stop  = press[1];
    assign p_lap   = press[2];
    assign p_clear = press[3];

    assign state    = cur;
    assign running  = (cur == RUN) || (cur == LAP);
    assign lap_next = (lap_count == 4'd15) ? lap_count : lap_count + 4'd1;

    // The prescaler advances on any edge taken while counting, so a wrap on the
    // edge that consumes a stop still produces its tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= IDLE;
            presc       <= '0;
            tick_en     <= 1'b0;
            cnt_clr     <= 1'b0;
            disp_freeze <= 1'b0;
            lap_count   <= 4'd0;
        end else begin
            tick_en <= 1'b0;
            cnt_clr <= 1'b0;

            if (running) begin
                if (presc == PRESC_LAST) begin
                    presc   <= '0;
                    tick_en <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end else if (cur == IDLE) begin
                presc <= '0;
            end

            case (cur)
                IDLE: begin
                    if (p_clear) begin
                        cnt_clr   <= 1'b1;
                        lap_count <= 4'd0;
                    end else if (p_start) begin
                        cur   <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (p_stop) begin
                        cur <= PAUSE;
                    end else if (p_lap) begin
                        cur         <= LAP;
                        disp_freeze <= 1'b1;
                        lap_count   <= lap_next;
                    end
                end
                LAP: begin
                    if (p_stop) begin
                        cur         <= PAUSE;
                        disp_freeze <= 1'b0;
                    end else if (p_lap) begin
                        cur         <= RUN;
                        disp_freeze <= 1'b0;
                        lap_count   <= lap_next;
                    end
                end
                PAUSE: begin
                    if (p_clear) begin
                        cur       <= IDLE;
                        cnt_clr   <= 1'b1;
                        presc     <= '0;
                        lap_count <= 4'd0;
                    end else if (p_start) begin
                        cur <= RUN;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a behavioural reference checked every cycle, plus
// directed button sequences with hand-computed timing expectations.
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;

    localparam logic [3:0] START = 4'b0001;
    localparam logic [3:0] STOP  = 4'b0010;
    localparam logic [3:0] LAPB  = 4'b0100;
    localparam logic [3:0] CLEAR = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       tick_en;
    logic       cnt_clr;
    logic       disp_freeze;
    logic       running;
    logic [1:0] state;
    logic [3:0] lap_count;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .TICK_DIV   (TD),
        .DEB_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start   (btn[0]),
        .btn_stop    (btn[1]),
        .btn_lap     (btn[2]),
        .btn_clear   (btn[3]),
        .tick_en     (tick_en),
        .cnt_clr     (cnt_clr),
        .disp_freeze (disp_freeze),
        .running     (running),
        .state       (state),
        .lap_count   (lap_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the given buttons from the next edge until the edge that consumes
    // the resulting press, then releases them.
    task automatic applyStimulus(input logic [3:0] mask);
        btn = mask;
        waitCycles(DB + 3);
        btn = 4'b0000;
    endtask

    // Reference model: states as plain integers 0..3, prescaler as the count of
    // running edges modulo TD, buttons as accepted levels with streak lengths.
    int       m_state  = 0;
    int       m_presc  = 0;
    int       m_lap    = 0;
    bit       m_tick   = 0;
    bit       m_clr    = 0;
    bit       m_freeze = 0;
    bit [3:0] m_d1     = '0;
    bit [3:0] m_d2     = '0;
    bit [3:0] m_acc    = '0;
    bit [3:0] m_pend   = '0;
    bit [3:0] m_p;
    int       m_streak [4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_presc = 0; m_lap = 0;
            m_tick = 0; m_clr = 0; m_freeze = 0;
            m_d1 = '0; m_d2 = '0; m_acc = '0; m_pend = '0;
            for (int i = 0; i < 4; i++) m_streak[i] = 0;
        end else begin
            m_p    = m_pend;
            m_tick = 0;
            m_clr  = 0;
            if (m_state == 1 || m_state == 3) begin
                m_presc = (m_presc + 1) % TD;
                m_tick  = (m_presc == 0);
            end
            case (m_state)
                0: if (m_p[3]) begin m_clr = 1; m_lap = 0; end
                   else if (m_p[0]) begin m_state = 1; m_presc = 0; end
                1: if (m_p[1]) m_state = 2;
                   else if (m_p[2]) begin m_state = 3; m_freeze = 1; m_lap = (m_lap < 15) ? m_lap + 1 : 15; end
                3: if (m_p[1]) begin m_state = 2; m_freeze = 0; end
                   else if (m_p[2]) begin m_state = 1; m_freeze = 0; m_lap = (m_lap < 15) ? m_lap + 1 : 15; end
                default: if (m_p[3]) begin m_state = 0; m_clr = 1; m_presc = 0; m_lap = 0; end
                   else if (m_p[0]) m_state = 1;
            endcase
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                if (m_d2[i] != m_acc[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DB) begin
                        m_acc[i]    = m_d2[i];
                        m_streak[i] = 0;
                        m_pend[i]   = m_acc[i];
                    end
                end else begin
                    m_streak[i] = 0;
                end
                m_d2[i] = m_d1[i];
                m_d1[i] = btn[i];
            end
        end
    end

    // Continuous comparison against the reference on every falling edge.
    always @(negedge clk) begin
        checkOutput("state", int'(state), m_state);
        checkOutput("running", int'(running), (m_state == 1 || m_state == 3) ? 1 : 0);
        checkOutput("tick_en", int'(tick_en), int'(m_tick));
        checkOutput("cnt_clr", int'(cnt_clr), int'(m_clr));
        checkOutput("disp_freeze", int'(disp_freeze), int'(m_freeze));
        checkOutput("lap_count", int'(lap_count), m_lap);
    end

    int tick_seen;
    int pulse_cnt;

    initial begin
        $display("[TB] reset");
        waitCycles(3);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_running", int'(running), 0);
        checkOutput("reset_lap", int'(lap_count), 0);
        #2 rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] start held from IDLE");
        btn = START;
        waitCycles(6);
        checkOutput("start_edge6_state", int'(state), 0);
        waitCycles(1);
        checkOutput("start_edge7_state", int'(state), 1);
        checkOutput("start_edge7_running", int'(running), 1);
        waitCycles(3);
        btn = 4'b0000;
        waitCycles(6);
        checkOutput("tick_edge16", int'(tick_en), 0);
        waitCycles(1);
        checkOutput("tick_edge17", int'(tick_en), 1);
        waitCycles(1);
        checkOutput("tick_edge18", int'(tick_en), 0);
        waitCycles(9);
        checkOutput("tick_edge27", int'(tick_en), 1);
        checkOutput("no_clr_in_run", int'(cnt_clr), 0);

        $display("[TB] stop at prescaler 6, pause, resume");
        applyStimulus(STOP);
        checkOutput("stop_state", int'(state), 2);
        checkOutput("stop_running", int'(running), 0);
        pulse_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            waitCycles(1);
            pulse_cnt += int'(tick_en);
        end
        checkOutput("pause_ticks", pulse_cnt, 0);
        applyStimulus(START);
        checkOutput("resume_state", int'(state), 1);
        waitCycles(2);
        checkOutput("resume_tick_r2", int'(tick_en), 0);
        waitCycles(1);
        checkOutput("resume_tick_r3", int'(tick_en), 1);
        waitCycles(10);
        checkOutput("resume_tick_r13", int'(tick_en), 1);

        $display("[TB] laps");
        for (int k = 1; k <= 3; k++) begin
            waitCycles(8);
            applyStimulus(LAPB);
            checkOutput("lap_state", int'(state), (k % 2 == 1) ? 3 : 1);
            checkOutput("lap_freeze", int'(disp_freeze), (k % 2 == 1) ? 1 : 0);
            checkOutput("lap_count_k", int'(lap_count), k);
        end
        for (int k = 4; k <= 17; k++) begin
            waitCycles(8);
            applyStimulus(LAPB);
        end
        checkOutput("lap_saturated", int'(lap_count), 15);
        checkOutput("lap17_state", int'(state), 3);

        $display("[TB] stop from LAP, then stop+clear in PAUSE");
        waitCycles(8);
        applyStimulus(STOP);
        checkOutput("lapstop_state", int'(state), 2);
        checkOutput("lapstop_freeze", int'(disp_freeze), 0);
        waitCycles(8);
        applyStimulus(STOP | CLEAR);
        checkOutput("clearwins_state", int'(state), 0);
        checkOutput("clearwins_clr", int'(cnt_clr), 1);
        checkOutput("clearwins_lap", int'(lap_count), 0);
        waitCycles(1);
        checkOutput("clr_one_cycle", int'(cnt_clr), 0);

        $display("[TB] bouncing start");
        waitCycles(8);
        for (int r = 0; r < 2; r++) begin
            btn = START;
            waitCycles(2);
            btn = 4'b0000;
            waitCycles(2);
        end
        btn = START;
        waitCycles(6);
        checkOutput("bounce_edge6_state", int'(state), 0);
        waitCycles(1);
        checkOutput("bounce_edge7_state", int'(state), 1);
        btn = 4'b0000;

        $display("[TB] clear ignored in RUN");
        waitCycles(8);
        applyStimulus(CLEAR);
        checkOutput("clear_run_state", int'(state), 1);
        checkOutput("clear_run_clr", int'(cnt_clr), 0);

        $display("[TB] reset mid-LAP");
        waitCycles(8);
        applyStimulus(LAPB);
        checkOutput("lap_again_state", int'(state), 3);
        tick_seen = 0;
        for (int i = 0; i < 20 && tick_seen == 0; i++) begin
            waitCycles(1);
            if (tick_en) tick_seen = 1;
        end
        checkOutput("lap_tick_seen", tick_seen, 1);
        waitCycles(8);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state", int'(state), 0);
        checkOutput("async_rst_running", int'(running), 0);
        checkOutput("async_rst_freeze", int'(disp_freeze), 0);
        checkOutput("async_rst_lap", int'(lap_count), 0);
        checkOutput("async_rst_tick", int'(tick_en), 0);
        checkOutput("async_rst_clr", int'(cnt_clr), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            pulse_cnt += int'(tick_en) + int'(cnt_clr);
        end
        checkOutput("post_reset_pulses", pulse_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
